svc_soc_io_pwm: RTL

Downstream consumer of the SoC I/O register bank's outputs. It turns the MMIO-written LED enable bit and 8-bit GPIO value into a brightness-controlled PWM pin. Duty updates are double-buffered and take effect only at period boundaries, so software writes never produce a truncated or glitched pulse. The block sits between the register bank's led/gpio outputs and the board LED pin.

---
 rtl/svc_soc_io_pwm.sv | 136 +++++++++++++
 1 files changed

// File: rtl/svc_soc_io_pwm.sv
// ---------------------------------------------------------------------------
// svc_soc_io_pwm
//
// Brightness-controlled PWM driver for the board LED. It sits downstream of
// the SoC I/O register bank: the bank's led bit enables the PWM and its 8-bit
// gpio value selects the duty in 1/256 steps.
//
// Duty is double-buffered. The requested duty is copied into duty_active only
// while idle, on the IDLE->RUN edge, and at the end of each 256-count
// period. A software write therefore never truncates or stretches a pulse
// already in progress.
//
// Each PWM count step lasts PRESCALE clk cycles, so one period is
// 256*PRESCALE cycles. pwm is registered and lags the period counter by one
// clk, which also removes any combinational path from inputs to outputs.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   en            PWM enable (register bank led output)
//   duty          requested duty, 1/256 units (register bank gpio output)
//   pwm           registered PWM output to the pin
//   period_start  one-cycle pulse on the first cycle of every PWM period
//   duty_active   shadow duty currently in effect (registered)
// ---------------------------------------------------------------------------
module svc_soc_io_pwm #(
    parameter int PRESCALE   = 1,
    parameter int PRESCALE_W = $clog2(PRESCALE + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] duty,
    output logic       pwm,
    output logic       period_start,
    output logic [7:0] duty_active
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PRESCALE_W-1:0] PRESC_LAST = PRESCALE_W'(PRESCALE - 1);
    localparam logic [PRESCALE_W-1:0] PRESC_ONE  = PRESCALE_W'(1);

    state_t                state;
    state_t                state_next;
    logic [PRESCALE_W-1:0] presc;
    logic [PRESCALE_W-1:0] presc_next;
    logic [7:0]            cnt;
    logic [7:0]            cnt_next;
    logic [7:0]            duty_active_next;
    logic                  pwm_next;
    logic                  period_start_next;
    logic                  tick;

    // One count step has elapsed; with PRESCALE=1 this is every cycle.
    assign tick = (presc == PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next        = state;
        presc_next        = presc;
        cnt_next          = cnt;
        duty_active_next  = duty_active;
        pwm_next          = 1'b0;
        period_start_next = 1'b0;

        case (state)
            IDLE: begin
                // The shadow tracks the request while idle, so the
                // IDLE->RUN edge automatically latches the current duty.
                duty_active_next = duty;
                presc_next       = '0;
                cnt_next         = '0;
                if (en) begin
                    state_next        = RUN;
                    period_start_next = 1'b1;
                end
            end

            RUN: begin
                if (!en) begin
                    // Abandon the period immediately; pwm drops on this edge.
                    state_next = IDLE;
                    presc_next = '0;
                    cnt_next   = '0;
                end else begin
                    // Compare uses the pre-edge count, giving the one-cycle lag.
                    pwm_next = (cnt < duty_active);
                    if (tick) begin
                        presc_next = '0;
                        cnt_next   = cnt + 8'd1;
                        if (cnt == 8'hFF) begin
                            // Period boundary: the only point in RUN where
                            // a new duty is accepted.
                            duty_active_next  = duty;
                            period_start_next = 1'b1;
                        end
                    end else begin
                        presc_next = presc + PRESC_ONE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc        <= '0;
            cnt          <= '0;
            duty_active  <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            presc        <= presc_next;
            cnt          <= cnt_next;
            duty_active  <= duty_active_next;
            pwm          <= pwm_next;
            period_start <= period_start_next;
        end
    end

endmodule
